// File: rtl/draw_rect_fill_if.sv
// Command and pixel-port bundle for draw_rect_fill. The req_outline field exists
// only when DRAW_RECT_OUTLINE_EN is defined.
interface draw_rect_fill_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [7:0] req_w;
  logic [6:0] req_h;
  logic [2:0] req_colour;
  logic       req_clear;
`ifdef DRAW_RECT_OUTLINE_EN
  logic       req_outline;
`endif
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  // master: command source / adapter side; slave: the fill engine
  modport master (
`ifdef DRAW_RECT_OUTLINE_EN
    output req_outline,
`endif
    output req_valid, req_x, req_y, req_w, req_h, req_colour, req_clear,
    input  req_ready, x, y, colour, plot, busy, done
  );

  modport slave (
`ifdef DRAW_RECT_OUTLINE_EN
    input  req_outline,
`endif
    input  req_valid, req_x, req_y, req_w, req_h, req_colour, req_clear,
    output req_ready, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/draw_rect_fill.sv
// Handshaked, clipped rectangle fill for the 160x120 VGA adapter: one pixel per clock.
// Optional perimeter-only drawing is enabled by defining DRAW_RECT_OUTLINE_EN.
module draw_rect_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  draw_rect_fill_if.slave  bus
);

  localparam logic [8:0] W9 = 9'(SCREEN_W);
  localparam logic [8:0] H9 = 9'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t     r_state;
  logic [7:0] r_x0;
  logic [7:0] r_xend;
  logic [6:0] r_y0;
  logic [6:0] r_yend;
  logic       r_outline;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_busy;
  logic       r_done;

  logic [8:0] w_x9;
  logic [8:0] w_y9;
  logic [8:0] w_w9;
  logic [8:0] w_h9;
  logic [8:0] w_wmax;
  logic [8:0] w_hmax;
  logic [8:0] w_ew;
  logic [8:0] w_eh;
  logic [7:0] w_x0;
  logic [6:0] w_y0;
  logic [7:0] w_xend;
  logic [6:0] w_yend;
  logic       w_empty;
  logic       w_outline;

  logic       w_row_end;
  logic       w_last;
  logic [7:0] w_nx;
  logic [6:0] w_ny;
  logic       w_edge;

  // Clip the incoming command in 9 bits so off-screen origins never wrap.
  always_comb begin
    w_x9   = {1'b0, bus.req_x};
    w_y9   = {2'b00, bus.req_y};
    w_w9   = {1'b0, bus.req_w};
    w_h9   = {2'b00, bus.req_h};
    w_wmax = W9 - w_x9;
    w_hmax = H9 - w_y9;
    if (bus.req_clear) begin
      w_x0 = 8'd0;
      w_y0 = 7'd0;
      w_ew = W9;
      w_eh = H9;
    end else begin
      w_x0 = bus.req_x;
      w_y0 = bus.req_y;
      w_ew = (w_x9 >= W9) ? 9'd0 : ((w_w9 < w_wmax) ? w_w9 : w_wmax);
      w_eh = (w_y9 >= H9) ? 9'd0 : ((w_h9 < w_hmax) ? w_h9 : w_hmax);
    end
    w_empty = (w_ew == 9'd0) || (w_eh == 9'd0);
    w_xend  = w_x0 + w_ew[7:0] - 8'd1;
    w_yend  = w_y0 + w_eh[6:0] - 7'd1;
  end

`ifdef DRAW_RECT_OUTLINE_EN
  assign w_outline = bus.req_outline & ~bus.req_clear;
`else
  assign w_outline = 1'b0;
`endif

  // Raster stepping from the pixel currently on the output registers.
  always_comb begin
    w_row_end = (r_x == r_xend);
    w_last    = w_row_end && (r_y == r_yend);
    w_nx      = w_row_end ? r_x0 : r_x + 8'd1;
    w_ny      = w_row_end ? r_y + 7'd1 : r_y;
    w_edge    = (w_nx == r_x0) || (w_nx == r_xend) ||
                (w_ny == r_y0) || (w_ny == r_yend);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.req_valid) begin
            r_x0      <= w_x0;
            r_y0      <= w_y0;
            r_xend    <= w_xend;
            r_yend    <= w_yend;
            r_outline <= w_outline;
            r_busy    <= 1'b1;
            if (w_empty) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_DRAW;
              r_x      <= w_x0;
              r_y      <= w_y0;
              r_colour <= bus.req_colour;
              r_plot   <= 1'b1;
            end
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_plot  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_x    <= w_nx;
            r_y    <= w_ny;
            r_plot <= ~r_outline | w_edge;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Ready is forced low for as long as reset is held, even in IDLE.
  assign bus.req_ready = (r_state == S_IDLE) && !reset;
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.colour    = r_colour;
  assign bus.plot      = r_plot;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_draw_rect_fill.sv
// Bench for draw_rect_fill: a per-cycle expected-output queue built from the clip
// and raster rules, plus hand-computed literal checks for each directed command.
module tb_draw_rect_fill;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  draw_rect_fill_if bus();
  draw_rect_fill dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit idle; bit plot; bit done; bit chk_xy;
    int x; int y; int col;
  } rec_t;

  function automatic rec_t mk(bit idle, bit plot, bit done, bit c, int x, int y, int col);
    rec_t r;
    r.idle = idle; r.plot = plot; r.done = done; r.chk_xy = c;
    r.x = x; r.y = y; r.col = col;
    return r;
  endfunction

  rec_t q[$];
  rec_t cur;
  bit   model_on = 1'b0;
  bit   tb_outl;
`ifdef DRAW_RECT_OUTLINE_EN
  assign tb_outl = bus.req_outline;
`else
  assign tb_outl = 1'b0;
`endif

  function automatic void build(int rx, int ry, int rw, int rh, int col, bit clr, bit outl);
    int x0, y0, ew, eh;
    bit p;
    x0 = rx; y0 = ry;
    if (clr) begin
      x0 = 0; y0 = 0; ew = 160; eh = 120; outl = 1'b0;
    end else begin
      ew = (rx >= 160) ? 0 : ((rw < 160 - rx) ? rw : 160 - rx);
      eh = (ry >= 120) ? 0 : ((rh < 120 - ry) ? rh : 120 - ry);
    end
    for (int yy = y0; yy < y0 + eh; yy++)
      for (int xx = x0; xx < x0 + ew; xx++) begin
        p = !outl || xx == x0 || xx == x0 + ew - 1 || yy == y0 || yy == y0 + eh - 1;
        q.push_back(mk(1'b0, p, 1'b0, p, xx, yy, col));
      end
    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
      model_on = 1'b1;
    end else if (model_on) begin
      if (cur.idle && bus.req_valid)
        build(bus.req_x, bus.req_y, bus.req_w, bus.req_h, bus.req_colour, bus.req_clear, tb_outl);
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("ready", bus.req_ready, (cur.idle && !rst) ? 1 : 0);
      chk("plot", bus.plot, cur.plot);
      chk("busy", bus.busy, cur.idle ? 0 : 1);
      chk("done", bus.done, cur.done);
      if (cur.chk_xy) begin
        chk("x", bus.x, cur.x);
        chk("y", bus.y, cur.y);
        chk("colour", bus.colour, cur.col);
      end
    end
  end

  // ---------------- monitor for literal checks ----------------
  int mon_cnt, fx, fy, fc, lx, ly, lc, done_cnt, done_cyc, low_cnt, low_first, low_last;

  task automatic mon_clear();
    mon_cnt = 0; fx = -1; fy = -1; fc = -1; lx = -1; ly = -1; lc = -1;
    done_cnt = 0; done_cyc = -1; low_cnt = 0; low_first = -1; low_last = -1;
  endtask

  always @(negedge clk) begin
    if (bus.plot) begin
      if (mon_cnt == 0) begin fx = bus.x; fy = bus.y; fc = cyc; end
      lx = bus.x; ly = bus.y; lc = cyc;
      mon_cnt++;
    end
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (bus.busy && !bus.done && !bus.plot) begin
      if (low_cnt == 0) low_first = cyc;
      low_last = cyc;
      low_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  int acc;

  task automatic drive(int rx, int ry, int rw, int rh, int col, bit clr, bit outl);
    bus.req_x = rx[7:0]; bus.req_y = ry[6:0]; bus.req_w = rw[7:0]; bus.req_h = rh[6:0];
    bus.req_colour = col[2:0]; bus.req_clear = clr;
`ifdef DRAW_RECT_OUTLINE_EN
    bus.req_outline = outl;
`else
    if (outl) $display("note: outline request ignored in this build");
`endif
    bus.req_valid = 1'b1;
  endtask

  // Waits for done (bounded), then returns #1 after the edge that ends the done cycle.
  task automatic wait_done(int limit, bit hold);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < limit);
    if (!bus.done) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    if (hold) bus.req_valid = 1'b0;
  endtask

  task automatic send(int rx, int ry, int rw, int rh, int col, bit clr, bit outl, bit hold, int limit);
    int n;
    @(posedge clk); #1;
    mon_clear();
    drive(rx, ry, rw, rh, col, clr, outl);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 10) begin @(negedge clk); n++; end
    acc = cyc;
    if (!bus.req_ready) begin
      chk("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
    end else begin
      if (!hold) begin @(posedge clk); #1; bus.req_valid = 1'b0; end
      wait_done(limit, hold);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0;
    bus.req_colour = '0; bus.req_clear = 1'b0;
`ifdef DRAW_RECT_OUTLINE_EN
    bus.req_outline = 1'b0;
`endif
    mon_clear();

    // reset: two cycles
    @(posedge clk); #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_plot", bus.plot, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.req_ready, 1);

    // basic fill
    send(10, 5, 3, 2, 3'b100, 1'b0, 1'b0, 1'b0, 100);
    chk("basic_cnt", mon_cnt, 6);
    chk("basic_first_cyc", fc - acc, 1);
    chk("basic_fx", fx, 10);
    chk("basic_fy", fy, 5);
    chk("basic_lx", lx, 12);
    chk("basic_ly", ly, 6);
    chk("basic_last_cyc", lc - acc, 6);
    chk("basic_done_cyc", done_cyc - acc, 7);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_ready_again", bus.req_ready, 1);

    // clip at bottom-right corner
    send(158, 119, 5, 4, 3'b010, 1'b0, 1'b0, 1'b0, 100);
    chk("clip_cnt", mon_cnt, 2);
    chk("clip_fx", fx, 158);
    chk("clip_fy", fy, 119);
    chk("clip_lx", lx, 159);
    chk("clip_ly", ly, 119);
    chk("clip_done_cyc", done_cyc - acc, 3);

    // vertical clip only
    send(3, 118, 2, 9, 3'b111, 1'b0, 1'b0, 1'b0, 100);
    chk("vclip_cnt", mon_cnt, 4);
    chk("vclip_ly", ly, 119);

    // degenerate: zero width, then off-screen origin
    send(20, 20, 0, 7, 3'b001, 1'b0, 1'b0, 1'b0, 100);
    chk("w0_cnt", mon_cnt, 0);
    chk("w0_done_cyc", done_cyc - acc, 1);
    send(200, 10, 5, 5, 3'b001, 1'b0, 1'b0, 1'b0, 100);
    chk("x200_cnt", mon_cnt, 0);
    chk("x200_done_cyc", done_cyc - acc, 1);

    // full clear with req_valid held through busy
    send(77, 33, 1, 1, 3'b000, 1'b1, 1'b0, 1'b1, 20000);
    chk("clr_cnt", mon_cnt, 19200);
    chk("clr_fx", fx, 0);
    chk("clr_fy", fy, 0);
    chk("clr_lx", lx, 159);
    chk("clr_ly", ly, 119);
    chk("clr_done_cyc", done_cyc - acc, 19201);
    chk("clr_done_cnt", done_cnt, 1);

    // reset at pixel 4 of a 20-pixel fill
    @(posedge clk); #1;
    mon_clear();
    drive(20, 10, 5, 4, 3'b110, 1'b0, 1'b0);
    @(negedge clk);
    chk("rmid_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmid_p4_plot", bus.plot, 1);
    chk("rmid_p4_x", bus.x, 23);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmid_plot", bus.plot, 0);
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_x", bus.x, 0);
    chk("rmid_y", bus.y, 0);
    chk("rmid_done", bus.done, 0);
    #1;
    chk("rmid_ready_after", bus.req_ready, 1);
    drive(1, 1, 2, 1, 3'b011, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rmid_new_busy", bus.busy, 1);
    wait_done(100, 1'b0);
    chk("rmid_done_cnt", done_cnt, 1);
    chk("rmid_cnt", mon_cnt, 6);

`ifdef DRAW_RECT_OUTLINE_EN
    send(0, 0, 4, 3, 3'b101, 1'b0, 1'b1, 1'b0, 100);
    chk("ol_cnt", mon_cnt, 10);
    chk("ol_low_cnt", low_cnt, 2);
    chk("ol_low_first", low_first - acc, 6);
    chk("ol_low_last", low_last - acc, 7);
    chk("ol_done_cyc", done_cyc - acc, 13);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
